// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer,
// flush-to-bubble, sticky halt capture and a saturating stall counter.
module pipe_stage_buf #(
  parameter int                   PAYLOAD_W  = 64,
  parameter logic [PAYLOAD_W-1:0] BUBBLE_VAL = {PAYLOAD_W{1'b0}},
  parameter int                   CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  input  logic                 in_halt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic                 out_halt,
  output logic                 halted,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] data;
    logic                 halt;
  } entry_t;

  state_e            state_q, state_d;
  entry_t            main_q, main_d;
  entry_t            skid_q, skid_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              accept, drain;
  entry_t            in_ent;

  // in_ready must never look at out_ready so upstream timing stays registered
  assign in_ready  = ~flush & ~halted_q & (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  assign in_ent    = '{data: in_data, halt: in_halt};

  assign out_data  = out_valid ? main_q.data : BUBBLE_VAL;
  assign out_halt  = out_valid & main_q.halt;
  assign halted    = halted_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    halted_d = halted_q | (accept & in_halt);
    if (flush) begin
      state_d  = S_EMPTY;
      halted_d = 1'b0;
    end else begin
      unique case (state_q)
        S_EMPTY: if (accept) begin
          main_d  = in_ent;
          state_d = S_ONE;
        end
        S_ONE: begin
          if (accept && drain) begin
            main_d = in_ent;
          end else if (accept) begin
            skid_d  = in_ent;
            state_d = S_TWO;
          end else if (drain) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: if (drain) begin
          main_d  = skid_q;
          state_d = S_ONE;
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Counts regardless of flush; only reset clears it
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && stall_cnt_q != {CNT_W{1'b1}})
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: reset, streaming, skid, flush, halt,
// stall counter saturation and mid-operation reset.
module tb_pipe_stage_buf;
  localparam int              PW  = 16;
  localparam int              CW  = 4;
  localparam logic [PW-1:0]   BUB = 16'hDEAD;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, in_halt;
  logic [PW-1:0] in_data, out_data;
  logic          out_valid, out_ready, out_halt, halted;
  logic [CW-1:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  pipe_stage_buf #(.PAYLOAD_W(PW), .BUBBLE_VAL(BUB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_halt(in_halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_halt(out_halt), .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 16'h0055;
    in_halt = 1'b0; out_ready = 1'b0;

    // Reset held two cycles with in_valid high
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'(BUB));
    chk("rst_out_halt",  32'(out_halt),  32'd0);
    chk("rst_halted",    32'(halted),    32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0; in_valid = 1'b0; #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // Streaming: one beat per cycle, visible right after its accept edge
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 16'h1000 + 16'(i); #1;
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_data",  32'(out_data),  32'h1000 + 32'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", 32'(out_valid), 32'd0);
    chk("stream_no_stall", 32'(stall_cnt), 32'd0);

    // Skid: drop out_ready for 3 cycles while upstream keeps offering
    in_valid = 1'b1; in_data = 16'h2000;
    tick();
    out_ready = 1'b0; in_data = 16'h2001; #1;
    chk("skid_absorb_ready", 32'(in_ready), 32'd1);
    tick();
    in_data = 16'h2002; #1;
    chk("skid_full_ready", 32'(in_ready), 32'd0);
    tick(); tick();
    chk("skid_head",      32'(out_data),  32'h2000);
    chk("skid_in_ready",  32'(in_ready),  32'd0);
    chk("skid_stall_cnt", 32'(stall_cnt), 32'd3);
    out_ready = 1'b1;
    tick();
    chk("skid_rel_data",  32'(out_data),  32'h2001);
    chk("skid_rel_ready", 32'(in_ready),  32'd1);
    tick();
    chk("skid_rel_data2", 32'(out_data),  32'h2002);
    in_valid = 1'b0;
    tick();
    chk("skid_empty",     32'(out_valid), 32'd0);
    chk("skid_cnt_hold",  32'(stall_cnt), 32'd3);

    // Flush with TWO holding 0xA,0xB and a beat offered
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h000A;
    tick();
    in_data = 16'h000B;
    tick();
    chk("flush_pre_head", 32'(out_data), 32'h000A);
    in_data = 16'h000C; flush = 1'b1; #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid",    32'(out_valid), 32'd0);
    chk("flush_data",     32'(out_data),  32'(BUB));
    chk("flush_cnt",      32'(stall_cnt), 32'd5);
    out_ready = 1'b1;
    tick();
    chk("flush_stays_empty", 32'(out_valid), 32'd0);

    // Halt: 0x1, 0x2(halt), then 0x3 must never enter
    in_valid = 1'b1; in_data = 16'h0001; in_halt = 1'b0;
    tick();
    chk("halt_b1_data", 32'(out_data), 32'h0001);
    chk("halt_b1_halt", 32'(out_halt), 32'd0);
    in_data = 16'h0002; in_halt = 1'b1;
    tick();
    in_data = 16'h0003; in_halt = 1'b0;
    chk("halt_b2_data", 32'(out_data), 32'h0002);
    chk("halt_b2_halt", 32'(out_halt), 32'd1);
    chk("halt_sticky",  32'(halted),   32'd1);
    chk("halt_ready",   32'(in_ready), 32'd0);
    tick();
    chk("halt_drained", 32'(out_valid), 32'd0);
    tick();
    chk("halt_b3_blocked", 32'(out_valid), 32'd0);
    chk("halt_still",      32'(halted),    32'd1);
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    chk("halt_cleared",   32'(halted),   32'd0);
    chk("halt_ready_back", 32'(in_ready), 32'd1);

    // Saturation: count from 5 with CNT_W=4 stops at 15
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0077;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("sat_pre", 32'(stall_cnt), 32'd14);
    for (int i = 0; i < 11; i++) tick();
    chk("sat_cnt",  32'(stall_cnt), 32'd15);
    chk("sat_hold", 32'(out_data),  32'h0077);

    // Reset mid-operation discards the held beat and clears the counter
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_cnt",   32'(stall_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, flush-to-bubble, sticky halt capture and a saturating stall counter. It generalises the fixed-field, write-enable-only stage registers (F/D, D/X, X/M, M/W). Each boundary instantiates it with a packed payload (instruction, PCs, control bits) and receives stall and flush from hazard control as handshake and flush inputs.

## Interface
- PAYLOAD_W, 64, width of packed payload (e.g. instruction + oldPC + newPC + branch PC)
- BUBBLE_VAL, {PAYLOAD_W{1'b0}}, value driven on out_data whenever out_valid=0 (NOP encoding)
- CNT_W, 16, width of the stall counter
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  discard all held entries and any input this cycle
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage can accept a beat this cycle
- in_data  input  PAYLOAD_W  upstream payload
- in_halt  input  1  beat carries HLT
- out_valid  output  1  beat presented downstream
- out_ready  input  1  downstream accepts this cycle
- out_data  output  PAYLOAD_W  payload of head entry
- out_halt  output  1  head entry carries HLT
- halted  output  1  sticky: a halt beat has been accepted
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Storage: main entry (drives outputs) and skid entry. Each entry holds payload and halt bit.
- States: EMPTY (no entries), ONE (main full), TWO (main and skid full).
- in_ready = ~flush & ~halted & (state != TWO). It is combinational from registered state and flush only. It never depends on out_ready.
- An accept occurs when in_valid & in_ready. A drain occurs when out_valid & out_ready.
- EMPTY:
  - accept: load main, go to ONE.
  - otherwise: stay.
- ONE:
  - accept & drain: reload main, stay ONE.
  - accept & ~drain: load skid, go to TWO.
  - drain & ~accept: go to EMPTY.
- TWO:
  - drain: skid moves to main, go to ONE. No accept is possible.
  - otherwise: hold.
- Beats leave in acceptance order. No beat is dropped or duplicated except on flush.
- out_valid = (state != EMPTY).
- When out_valid=0: out_data = BUBBLE_VAL and out_halt = 0.
- Halt:
  - halted sets on the cycle after an accept with in_halt=1.
  - Once set, in_ready stays 0. The halt beat and any earlier beats still drain normally.
- Flush:
  - Next state is EMPTY.
  - halted clears.
  - Any input this cycle is discarded (in_ready is 0).
  - stall_cnt is unaffected.
- stall_cnt increments each cycle with out_valid & ~out_ready. It holds at 2^CNT_W-1. It clears only on rst.
- Priority: rst > flush > normal handshake.

## Timing
- Reset values (the cycle after rst is sampled high):
  - state EMPTY, out_valid 0, out_data BUBBLE_VAL, out_halt 0.
  - halted 0, stall_cnt 0, in_ready 1 (when flush=0).
- Reset mid-operation discards both entries. No partial state survives.
- Latency: a beat accepted at edge N appears on out_data after edge N (same-cycle visibility downstream of that edge). Minimum stage latency is one cycle.
- Throughput is one beat per cycle when out_ready is held 1.
- Stall absorption: out_ready may drop with no upstream notice. One further beat is absorbed into skid; in_ready falls the following cycle.
- After out_ready rises in TWO, in_ready returns 1 one cycle later.
- flush and drain in the same cycle: the drain is still seen downstream (the handshake completes), then the stage empties.
- halt accepted with flush in the same cycle is impossible (in_ready=0). A halt held in an entry and then flushed is discarded and halted clears.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 → out_valid=0, out_data=BUBBLE_VAL, halted=0, stall_cnt=0; in_ready=1 after release.
- Streaming: 8 beats 0x1000..0x1007 with out_ready=1 → same 8 beats out in order, each one cycle after accept, no gaps.
- Skid: stream continuously and drop out_ready for 3 cycles → exactly 2 beats held (TWO), in_ready=0, stall_cnt=3; release → order preserved, no loss.
- Flush: state TWO holding 0xA,0xB and flush=1 with in_valid=1 → next cycle out_valid=0, out_data=BUBBLE_VAL; 0xA, 0xB and the input beat are never seen.
- Halt: beats 0x1, 0x2(halt), 0x3 offered → 0x1 and 0x2 (out_halt=1) drain, halted=1, in_ready=0, and 0x3 is never accepted; a later flush clears halted.
- Saturation: CNT_W=4, out_valid held with out_ready=0 for 20 cycles → stall_cnt stops at 15.
